// File: rtl/fma16_sched_if.sv
// Request/response channel between two requesters and the shared fma16 scheduler.
// Operand and control lanes are packed per requester: lane i = [W*i +: W].
interface fma16_sched_if #(
    parameter int unsigned W = 16
);
    localparam int unsigned CTRL_W = 6;
    localparam int unsigned FLAG_W = 4;

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*W-1:0]      req_x;
    logic [2*W-1:0]      req_y;
    logic [2*W-1:0]      req_z;
    logic [2*CTRL_W-1:0] req_ctrl;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [W-1:0]        rsp_result;
    logic [FLAG_W-1:0]   rsp_flags;

    modport master (
        output req_valid, req_x, req_y, req_z, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_x, req_y, req_z, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/fma16_sched.sv
// Round-robin sequencer sharing one multi-cycle fma16 core between two requesters.
// One op in flight: IDLE grants, EXEC holds operands LATENCY cycles, RESP returns the result.
module fma16_sched #(
    parameter int unsigned W       = 16,
    parameter int unsigned LATENCY = 3,
    localparam int unsigned CTRL_W = 6,
    localparam int unsigned FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    fma16_sched_if.slave      bus,
    output logic [W-1:0]      core_x_o,
    output logic [W-1:0]      core_y_o,
    output logic [W-1:0]      core_z_o,
    output logic [CTRL_W-1:0] core_ctrl_o,
    input  logic [W-1:0]      core_result_i,
    input  logic [FLAG_W-1:0] core_flags_i,
    output logic              busy_o
);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]        core_x_q, core_x_d;
    logic [W-1:0]        core_y_q, core_y_d;
    logic [W-1:0]        core_z_q, core_z_d;
    logic [CTRL_W-1:0]   core_ctrl_q, core_ctrl_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [W-1:0]        rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;

    logic                grant;
    logic                grant_vld;
    logic                rsp_hs;
    logic                cnt_zero;
    logic [1:0]          req_ready_c;

    // Arbiter: rr_ptr has priority, otherwise the other requester; only offered in IDLE.
    always_comb begin
        grant     = rr_ptr_q;
        grant_vld = 1'b0;
        if (state_q == S_IDLE) begin
            if (bus.req_valid[rr_ptr_q]) begin
                grant_vld = 1'b1;
            end else if (bus.req_valid[~rr_ptr_q]) begin
                grant     = ~rr_ptr_q;
                grant_vld = 1'b1;
            end
        end
    end

    assign req_ready_c = grant_vld ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_hs      = (state_q == S_RESP) && bus.rsp_ready[owner_q] && rsp_valid_q[owner_q];
    assign cnt_zero    = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_vld) state_d = S_EXEC;
            S_EXEC:  if (cnt_zero)  state_d = S_RESP;
            S_RESP:  if (rsp_hs)    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates; everything holds by default, including core_* and rsp_* in IDLE.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        core_x_d     = core_x_q;
        core_y_d     = core_y_q;
        core_z_d     = core_z_q;
        core_ctrl_d  = core_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    owner_d     = grant;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    core_x_d    = grant ? bus.req_x[2*W-1:W] : bus.req_x[W-1:0];
                    core_y_d    = grant ? bus.req_y[2*W-1:W] : bus.req_y[W-1:0];
                    core_z_d    = grant ? bus.req_z[2*W-1:W] : bus.req_z[W-1:0];
                    core_ctrl_d = grant ? bus.req_ctrl[2*CTRL_W-1:CTRL_W]
                                        : bus.req_ctrl[CTRL_W-1:0];
                end
            end
            S_EXEC: begin
                if (cnt_zero) begin
                    rsp_result_d = core_result_i;
                    rsp_flags_d  = core_flags_i;
                    rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 2'b00;
                    rr_ptr_d    = ~owner_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= 1'b0;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            core_x_q     <= '0;
            core_y_q     <= '0;
            core_z_q     <= '0;
            core_ctrl_q  <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            core_x_q     <= core_x_d;
            core_y_q     <= core_y_d;
            core_z_q     <= core_z_d;
            core_ctrl_q  <= core_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign core_x_o       = core_x_q;
    assign core_y_o       = core_y_q;
    assign core_z_o       = core_z_q;
    assign core_ctrl_o    = core_ctrl_q;
    assign busy_o         = (state_q != S_IDLE);
endmodule
